// File: rtl/cla_add_pipe_pkg.sv
// Shared definitions for the two-stage carry-lookahead adder: sizing, stage-1 record
// and the group-level lookahead used by both pipeline stages.
package cla_add_pipe_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int GRP       = 4;
    localparam int NGRP      = CLA_WIDTH / GRP;
    localparam int HALF      = CLA_WIDTH / 2;
    localparam int NGRP_HALF = NGRP / 2;

    typedef struct packed {
        logic [HALF-1:0] s_lo;
        logic            c_mid;
        logic            gp_lo;
        logic            gg_lo;
        logic            cin;
        logic [HALF-1:0] a_hi;
        logic [HALF-1:0] b_hi;
    } stage1_t;

    // Carry into group k of a half-word, written as a flat sum of products
    // (G[j] & P[j+1..k-1], plus ci & P[0..k-1]) so no group waits on its neighbour.
    function automatic logic lookahead_carry(input logic [NGRP_HALF-1:0] p,
                                             input logic [NGRP_HALF-1:0] g,
                                             input logic                 ci,
                                             input int                   k);
        logic c;
        logic t;
        c = ci;
        for (int j = 0; j < NGRP_HALF; j++) begin
            if (j < k) c = c & p[j];
        end
        for (int j = 0; j < NGRP_HALF; j++) begin
            if (j < k) begin
                t = g[j];
                for (int m = 0; m < NGRP_HALF; m++) begin
                    if (m > j && m < k) t = t & p[m];
                end
                c = c | t;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_add_4bit.sv
// 4-bit carry-lookahead slice: sum for a given carry in, plus group propagate/generate.
module cla_add_4bit
    import cla_add_pipe_pkg::*;
(
    input  logic [GRP-1:0] i_a,
    input  logic [GRP-1:0] i_b,
    input  logic           i_ci,
    output logic [GRP-1:0] o_s,
    output logic           o_p,
    output logic           o_g
);

    logic [GRP-1:0] w_p;
    logic [GRP-1:0] w_g;
    logic [GRP-1:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0] | (w_p[0] & i_ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_ci);

    assign o_s = w_p ^ w_c;
    assign o_p = &w_p;
    assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder s = a + b + cin with valid/ready on both sides.
// The lower half resolves in stage 1; its registered mid carry drives the upper half in stage 2.
module cla_add_pipe
    import cla_add_pipe_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             gp,
    output logic             gg,
    output logic             ovf
);

    // The stage-1 record is sized by the package, so WIDTH must track CLA_WIDTH.
    localparam int LH = WIDTH / 2;
    localparam int NH = LH / GRP;

    logic             r_v1;
    logic             r_v2;
    logic             w_ld1;
    logic             w_ld2;

    stage1_t          w_st1;
    stage1_t          r_st1;

    logic [LH-1:0]    w_s_lo;
    logic [NH-1:0]    w_gp_lo;
    logic [NH-1:0]    w_gg_lo;
    logic [NH-1:0]    w_gci_lo;

    logic [LH-1:0]    w_s_hi;
    logic [NH-1:0]    w_gp_hi;
    logic [NH-1:0]    w_gg_hi;
    logic [NH-1:0]    w_gci_hi;

    logic             w_gp_hi_all;
    logic             w_gg_hi_all;
    logic             w_gp;
    logic             w_gg;
    logic             w_cout;
    logic             w_c_msb;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_gp;
    logic             r_gg;
    logic             r_ovf;

    // Pipeline control
    assign w_ld2    = r_v1 & (~r_v2 | out_ready);
    assign w_ld1    = in_valid & in_ready;
    assign in_ready = ~r_v1 | w_ld2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_ld1 | (r_v1 & ~w_ld2);
            r_v2 <= w_ld2 | (r_v2 & ~out_ready);
        end
    end

    // Stage 1: lower half sum, mid carry and lower-half group P/G
    for (genvar k = 0; k < NH; k++) begin : g_lo
        cla_add_4bit u_grp (
            .i_a  (a[k*GRP +: GRP]),
            .i_b  (b[k*GRP +: GRP]),
            .i_ci (w_gci_lo[k]),
            .o_s  (w_s_lo[k*GRP +: GRP]),
            .o_p  (w_gp_lo[k]),
            .o_g  (w_gg_lo[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NH; k++) begin
            w_gci_lo[k] = lookahead_carry(w_gp_lo, w_gg_lo, cin, k);
        end
    end

    always_comb begin
        w_st1       = '0;
        w_st1.s_lo  = w_s_lo;
        w_st1.c_mid = lookahead_carry(w_gp_lo, w_gg_lo, cin, NH);
        w_st1.gp_lo = &w_gp_lo;
        w_st1.gg_lo = lookahead_carry(w_gp_lo, w_gg_lo, 1'b0, NH);
        w_st1.cin   = cin;
        w_st1.a_hi  = a[WIDTH-1:LH];
        w_st1.b_hi  = b[WIDTH-1:LH];
    end

    always_ff @(posedge clk) begin
        if (w_ld1) r_st1 <= w_st1;
    end

    // Stage 2: upper half from the registered mid carry, whole-word flags
    for (genvar k = 0; k < NH; k++) begin : g_hi
        cla_add_4bit u_grp (
            .i_a  (r_st1.a_hi[k*GRP +: GRP]),
            .i_b  (r_st1.b_hi[k*GRP +: GRP]),
            .i_ci (w_gci_hi[k]),
            .o_s  (w_s_hi[k*GRP +: GRP]),
            .o_p  (w_gp_hi[k]),
            .o_g  (w_gg_hi[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NH; k++) begin
            w_gci_hi[k] = lookahead_carry(w_gp_hi, w_gg_hi, r_st1.c_mid, k);
        end
    end

    assign w_gp_hi_all = &w_gp_hi;
    assign w_gg_hi_all = lookahead_carry(w_gp_hi, w_gg_hi, 1'b0, NH);
    assign w_gp        = r_st1.gp_lo & w_gp_hi_all;
    assign w_gg        = w_gg_hi_all | (w_gp_hi_all & r_st1.gg_lo);
    assign w_cout      = w_gg | (w_gp & r_st1.cin);
    // Carry into the sign bit, recovered from its sum bit and operands.
    assign w_c_msb     = w_s_hi[LH-1] ^ r_st1.a_hi[LH-1] ^ r_st1.b_hi[LH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_gp   <= 1'b0;
            r_gg   <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_ld2) begin
            r_s    <= {w_s_hi, r_st1.s_lo};
            r_cout <= w_cout;
            r_gp   <= w_gp;
            r_gg   <= w_gg;
            r_ovf  <= w_c_msb ^ w_cout;
        end
    end

    assign out_valid = r_v2;
    assign s         = r_s;
    assign cout      = r_cout;
    assign gp        = r_gp;
    assign gg        = r_gg;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_add_pipe.sv
// Scoreboard bench for cla_add_pipe: accepted beats push an arithmetic reference result,
// a separate monitor pops and compares on every output handshake.
module tb_cla_add_pipe;

    localparam int W = 16;

    typedef struct packed {
        logic         ovf;
        logic         gg;
        logic         gp;
        logic         cout;
        logic [W-1:0] s;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic         gp;
    logic         gg;
    logic         ovf;

    int           checks = 0;
    int           errors = 0;
    int unsigned  cyc = 0;
    res_t         sb[$];
    int unsigned  pop_cyc[$];
    logic         stall_prev = 1'b0;
    res_t         stall_snap;

    cla_add_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .gp        (gp),
        .gg        (gg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        res_t       r;
        logic [W:0] full;
        logic [W:0] gen;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        gen    = {1'b0, x} + {1'b0, y};
        r.s    = full[W-1:0];
        r.cout = full[W];
        r.gp   = &(x ^ y);
        r.gg   = gen[W];
        r.ovf  = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Input side: an accepted beat enqueues its reference result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) sb.push_back(model(a, b, cin));
    end

    always @(negedge rst_n) sb.delete();

    // Output side: stall stability and in-order result checking.
    always @(negedge clk) begin
        res_t cur;
        res_t exp;
        cur = {ovf, gg, gp, cout, s};
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", cur, stall_snap);
            end
            stall_prev <= out_valid && !out_ready;
            stall_snap <= cur;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp = sb.pop_front();
                    chk("result", cur, exp);
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        output int waited);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           w;
        int           idx;
        int unsigned  p0;
        logic [W-1:0] snap_s;
        logic [W-1:0] ta[3];
        logic [W-1:0] tb[3];
        logic         acc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {s, cout, gp, gg, ovf}, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Carry through every bit, latency of two cycles
        send(16'hFFFF, 16'h0001, 1'b0, w);
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        chk("t1_s", s, 16'h0000);
        chk("t1_flags", {cout, gp, gg, ovf}, 4'b1010);
        @(posedge clk);
        #1;

        // Signed overflow and full-propagate word
        send(16'h7FFF, 16'h0001, 1'b0, w);
        send(16'h5555, 16'hAAAA, 1'b1, w);
        @(negedge clk);
        chk("t2a_s", s, 16'h8000);
        chk("t2a_flags", {cout, ovf}, 2'b01);
        @(negedge clk);
        chk("t2b_s", s, 16'h0000);
        chk("t2b_flags", {cout, gp, gg}, 3'b110);
        @(posedge clk);
        #1;
        idle(3);

        // Back-to-back burst
        p0 = pop_cyc.size();
        acc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), w);
            if (w != 0) acc = 1'b0;
        end
        idle(4);
        chk("burst_in_ready", acc, 1);
        chk("burst_count", pop_cyc.size() - p0, 8);
        if (pop_cyc.size() >= p0 + 8) chk("burst_span", pop_cyc[p0 + 7] - pop_cyc[p0], 7);

        // Stall with three beats offered
        ta = '{16'h1111, 16'h8000, 16'hF0F0};
        tb = '{16'h2222, 16'h8000, 16'h0F0F};
        out_ready = 1'b0;
        idx = 0;
        snap_s = '0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) begin
                in_valid = 1'b1;
                a        = ta[idx];
                b        = tb[idx];
                cin      = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (c == 2) snap_s = s;
            @(posedge clk);
            #1;
        end
        chk("stall_accepted", idx, 2);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_s_hold", s, snap_s);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("stall_drained", sb.size(), 0);

        // Reset with both stages full
        out_ready = 1'b0;
        send(16'h0102, 16'h0304, 1'b0, w);
        send(16'h0506, 16'h0708, 1'b1, w);
        chk("full_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        chk("midrst_in_ready", in_ready, 1);
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send(16'h1234, 16'h4321, 1'b1, w);
        @(negedge clk);
        chk("post_rst_cycle1", out_valid, 0);
        @(negedge clk);
        chk("post_rst_cycle2", out_valid, 1);
        chk("post_rst_s", s, 16'h5556);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure
        acc = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                cin      = 1'($urandom);
                case ($urandom_range(0, 3))
                    0: begin a = W'($urandom); b = ~a; end
                    1: begin a = 16'hFFFF;     b = W'($urandom_range(0, 3)); end
                    2: begin a = W'($urandom); b = W'($urandom) & 16'h8000; end
                    default: begin a = W'($urandom); b = W'($urandom); end
                endcase
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) idle(1);
        chk("final_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
